// File: rtl/spi_rx_pkg.sv
// Shared types and helpers for the SPI frame receiver.
package spi_rx_pkg;

  localparam int unsigned DEF_WORD_W    = 16;
  localparam int unsigned DEF_NUM_WORDS = 3;

  typedef enum logic [1:0] {IDLE, RECV, HOLD, OVERRUN} spi_rx_state_e;

  // Mode 0 and mode 3 sample on the rising sclk edge, modes 1 and 2 on the falling one.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// SPI pins towards the receiver plus the committed-frame outputs it publishes.
interface spi_frame_rx_if
  import spi_rx_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned NUM_WORDS = DEF_NUM_WORDS
) ();

  logic                          sclk;
  logic                          mosi;
  logic                          ss_n;
  logic [NUM_WORDS*WORD_W-1:0]   frame_data;
  logic                          frame_valid;
  logic                          frame_err;
  logic [NUM_WORDS-1:0]          word_nonneg;
  logic                          busy;

  modport slave (
    input  sclk, mosi, ss_n,
    output frame_data, frame_valid, frame_err, word_nonneg, busy
  );

  modport master (
    output sclk, mosi, ss_n,
    input  frame_data, frame_valid, frame_err, word_nonneg, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall pulses on the synchronised level.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q      = sync_q[STAGES-1];
  assign rise_c = q & ~prev_q;
  assign fall_c = ~q & prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: oversamples the pins in the clk domain and publishes
// complete NUM_WORDS x WORD_W frames with a one-cycle valid strobe.
module spi_frame_rx
  import spi_rx_pkg::*;
#(
  parameter int unsigned WORD_W      = DEF_WORD_W,
  parameter int unsigned NUM_WORDS   = DEF_NUM_WORDS,
  parameter logic        CPOL        = 1'b0,
  parameter logic        CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           resetn,
  spi_frame_rx_if.slave  bus
);

  localparam int unsigned TOTAL   = NUM_WORDS * WORD_W;
  localparam int unsigned CNT_W   = $clog2(TOTAL);
  localparam int unsigned SET_W   = $clog2(SYNC_STAGES + 2);
  localparam logic        ON_RISE = sample_on_rise(CPOL, CPHA);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL - 1);
  localparam logic [SET_W-1:0] SETTLED  = SET_W'(SYNC_STAGES + 1);

  logic sclk_q_unused, sclk_rise_c, sclk_fall_c;
  logic ss_q, ss_rise_unused, ss_fall_c;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .resetn(resetn), .d(bus.sclk),
    .q(sclk_q_unused), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .resetn(resetn), .d(bus.ss_n),
    .q(ss_q), .rise_c(ss_rise_unused), .fall_c(ss_fall_c)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .resetn(resetn), .d(bus.mosi),
    .q(mosi_q), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
  );

  spi_rx_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TOTAL-1:0]  shift_q, shift_d;
  logic              commit_q, commit_d;
  logic              err_q, err_d;
  logic [SET_W-1:0]  settle_q;
  logic              settled_c;
  logic              sample_c;

  // A falling ss_n seen before the synchronisers have flushed their reset value is not a real frame start.
  assign settled_c = (settle_q == SETTLED);
  assign sample_c  = (ON_RISE ? sclk_rise_c : sclk_fall_c) & ~ss_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      if (!settled_c) settle_q <= settle_q + SET_W'(1);
    end
  end

  // ss_n high is checked before any sample edge so a coincident edge is dropped.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall_c && settled_c) begin
          state_d = RECV;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      RECV: begin
        if (ss_q) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (sample_c) begin
          shift_d = {shift_q[TOTAL-2:0], mosi_q};
          if (cnt_q == LAST_BIT) begin
            state_d  = HOLD;
            commit_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (ss_q) begin
          state_d = IDLE;
        end else if (sample_c) begin
          state_d = OVERRUN;
          err_d   = 1'b1;
        end
      end
      OVERRUN: begin
        if (ss_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // First received word sits at the top of the shift register but at the bottom of frame_data.
  logic [TOTAL-1:0]     ordered_c;
  logic [NUM_WORDS-1:0] nonneg_c;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    assign ordered_c[k*WORD_W +: WORD_W] = shift_q[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
    assign nonneg_c[k]                   = ~shift_q[(NUM_WORDS-1-k)*WORD_W + WORD_W - 1];
  end

  logic [TOTAL-1:0]     frame_data_q;
  logic [NUM_WORDS-1:0] word_nonneg_q;
  logic                 frame_valid_q, frame_err_q, busy_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_data_q  <= '0;
      word_nonneg_q <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_valid_q <= commit_q;
      frame_err_q   <= err_q;
      busy_q        <= (state_d != IDLE);
      if (commit_q) begin
        frame_data_q  <= ordered_c;
        word_nonneg_q <= nonneg_c;
      end
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.word_nonneg = word_nonneg_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = busy_q;

endmodule
